// File: rtl/shift_pkg.sv
// Shared constants and types for the shift datapath and its arbitrated front end.
package shift_pkg;

    localparam int unsigned SHIFT_W = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/shift_unit_arbiter_shift_core.sv
// Log-layer barrel shifters (layer i shifts by 2**i) and the combinational
// shift core that selects among them by opcode.
module shift_sll
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] x,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [SHIFT_W-1:0] result
);
    logic [SHAMT_W:0][SHIFT_W-1:0] stage;

    assign stage[0] = x;
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
        localparam int unsigned S = 1 << i;
        assign stage[i+1] = shamt[i] ? {stage[i][SHIFT_W-1-S:0], {S{1'b0}}} : stage[i];
    end
    assign result = stage[SHAMT_W];
endmodule

module shift_srl
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] x,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [SHIFT_W-1:0] result
);
    logic [SHAMT_W:0][SHIFT_W-1:0] stage;

    assign stage[0] = x;
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
        localparam int unsigned S = 1 << i;
        assign stage[i+1] = shamt[i] ? {{S{1'b0}}, stage[i][SHIFT_W-1:S]} : stage[i];
    end
    assign result = stage[SHAMT_W];
endmodule

module shift_sra
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] x,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [SHIFT_W-1:0] result
);
    logic [SHAMT_W:0][SHIFT_W-1:0] stage;

    assign stage[0] = x;
    // Each layer replicates the current MSB, which is always the original x[31].
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
        localparam int unsigned S = 1 << i;
        assign stage[i+1] = shamt[i] ? {{S{stage[i][SHIFT_W-1]}}, stage[i][SHIFT_W-1:S]}
                                     : stage[i];
    end
    assign result = stage[SHAMT_W];
endmodule

module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] x,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_t          op,
    output logic [SHIFT_W-1:0] result
);
    logic [SHIFT_W-1:0] sll_res;
    logic [SHIFT_W-1:0] srl_res;
    logic [SHIFT_W-1:0] sra_res;

    shift_sll u_sll (.x(x), .shamt(shamt), .result(sll_res));
    shift_srl u_srl (.x(x), .shamt(shamt), .result(srl_res));
    shift_sra u_sra (.x(x), .shamt(shamt), .result(sra_res));

    always_comb begin
        result = x;
        unique case (op)
            OP_SLL:  result = sll_res;
            OP_SRL:  result = srl_res;
            OP_SRA:  result = sra_res;
            OP_RSVD: result = x;
            default: result = x;
        endcase
    end
endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one shift core among NREQ requesters, with a
// single registered valid/ready output stage sustaining one result per cycle.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [SHIFT_W*NREQ-1:0] req_x,
    input  logic [SHIFT_W*NREQ-1:0] req_y,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [SHIFT_W-1:0]      resp_data,
    output logic [ID_W-1:0]         resp_id
);

    stage_state_t       state_q, state_d;
    logic [SHIFT_W-1:0] data_q, data_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               load_en;
    logic               found;
    logic [ID_W-1:0]    grant_idx;
    int unsigned        idx;

    logic [SHIFT_W-1:0] sel_x;
    logic [SHIFT_W-1:0] sel_y;
    logic [1:0]         sel_op;
    logic [SHIFT_W-1:0] shift_res;
    logic               unused_y_hi;

    assign load_en = (state_q == ST_EMPTY) || resp_ready;

    // Scan starting at rr_ptr so the most recently served requester is visited last.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && found && load_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_x  = req_x[i*SHIFT_W +: SHIFT_W];
                sel_y  = req_y[i*SHIFT_W +: SHIFT_W];
                sel_op = req_op[2*i +: 2];
            end
        end
    end

    assign unused_y_hi = ^sel_y[SHIFT_W-1:SHAMT_W];

    shift_core u_shift_core (
        .x      (sel_x),
        .shamt  (sel_y[SHAMT_W-1:0]),
        .op     (shift_op_t'(sel_op)),
        .result (shift_res)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            if (found) begin
                state_d  = ST_FULL;
                data_d   = shift_res;
                id_d     = grant_idx;
                rr_ptr_d = ID_W'((32'(grant_idx) + 32'd1) % NREQ);
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter (NREQ=2): directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_shift_unit_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_x;
    logic [63:0] req_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [0:0]  resp_id;

    int          total;
    int          bad;

    bit          m_valid;
    logic [31:0] m_data;
    int unsigned m_id;
    int unsigned m_rr;
    logic [1:0]  last_rdy;
    logic [31:0] saved_data;

    shift_unit_arbiter #(.NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                              input logic [4:0] s);
        case (op)
            2'd0:    return x << s;
            2'd1:    return x >> s;
            2'd2:    return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            default: return x;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_rr    = 0;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [1:0] op0, input logic [31:0] x0, input logic [31:0] y0,
                         input logic [1:0] op1, input logic [31:0] x1, input logic [31:0] y1,
                         input logic rdy);
        req_valid  = v;
        req_op     = {op1, op0};
        req_x      = {x1, x0};
        req_y      = {y1, y0};
        resp_ready = rdy;
    endtask

    // Called 1 time unit after a rising edge: checks the grant mid-cycle,
    // advances the model at the edge, then checks the registered response.
    task automatic step();
        bit          fnd;
        int unsigned g;
        int unsigned c;
        bit          load;
        logic [1:0]  exp_rdy;
        fnd = 1'b0;
        g   = 0;
        for (int k = 0; k < 2; k++) begin
            c = (m_rr + k) % 2;
            if (!fnd && req_valid[c]) begin
                fnd = 1'b1;
                g   = c;
            end
        end
        load    = !m_valid || resp_ready;
        exp_rdy = (fnd && load) ? 2'(1 << g) : 2'b00;
        #3;
        last_rdy = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (fnd && load) begin
            m_valid = 1'b1;
            m_data  = ref_shift(req_op[2*g +: 2], req_x[32*g +: 32], req_y[32*g +: 5]);
            m_id    = g;
            m_rr    = (g + 1) % 2;
        end else if (load) begin
            m_valid = 1'b0;
        end
        #1;
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("resp_data", resp_data, m_data);
        check("resp_id", 32'(resp_id), m_id);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        model_reset();
        drive(2'b11, 2'd0, 32'h1, 32'h1, 2'd0, 32'h1, 32'h1, 1'b1);
        #12;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        req_valid = 2'b00;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First grant after reset with both valid, req0 carries the SRA.
        drive(2'b11, 2'b10, 32'h8000_0000, 32'd4, 2'd0, 32'h5, 32'd1, 1'b1);
        step();
        check("first_grant", 32'(last_rdy), 32'h1);
        check("sra_valid", 32'(resp_valid), 32'h1);
        check("sra_data", resp_data, 32'hF800_0000);
        check("sra_id", 32'(resp_id), 32'h0);

        // Serve req1 alone so the pointer returns to req0.
        drive(2'b10, 2'd0, 32'h0, 32'h0, 2'd1, 32'hF0, 32'd4, 1'b1);
        step();
        check("req1_alone_id", 32'(resp_id), 32'h1);

        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'd0, 32'h3 + 32'(i), 32'(i), 2'd2, 32'h8000_0010, 32'(i), 1'b1);
            step();
            check("contend_valid", 32'(resp_valid), 32'h1);
            check("contend_id", 32'(resp_id), 32'(i % 2));
        end

        saved_data = m_data;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'd0, 32'hAAAA, 32'd3, 2'd1, 32'h5555, 32'd2, 1'b0);
            step();
            check("bp_ready", 32'(last_rdy), 32'h0);
            check("bp_data_stable", resp_data, saved_data);
            check("bp_id_stable", 32'(resp_id), 32'h1);
        end
        drive(2'b11, 2'd0, 32'hAAAA, 32'd3, 2'd1, 32'h5555, 32'd2, 1'b1);
        step();
        check("bp_drain_grant", 32'(last_rdy), 32'h1);
        check("bp_drain_valid", 32'(resp_valid), 32'h1);
        check("bp_drain_data", resp_data, 32'h5_5550);

        drive(2'b01, 2'd0, 32'h1, 32'd33, 2'd0, 32'h0, 32'h0, 1'b1);
        step();
        check("sll_y33", resp_data, 32'h2);
        drive(2'b01, 2'd1, 32'hFFFF_FFFF, 32'd31, 2'd0, 32'h0, 32'h0, 1'b1);
        step();
        check("srl_31", resp_data, 32'h1);
        drive(2'b01, 2'd3, 32'h1234_5678, 32'd7, 2'd0, 32'h0, 32'h0, 1'b1);
        step();
        check("op_rsvd", resp_data, 32'h1234_5678);

        drive(2'b01, 2'd0, 32'h5, 32'd1, 2'd0, 32'h0, 32'h0, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'h0);
        check("async_rst_data", resp_data, 32'h0);
        model_reset();
        req_valid = 2'b00;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(2'b11, 2'd0, 32'h7, 32'd2, 2'd0, 32'h9, 32'd1, 1'b1);
        step();
        check("post_rst_grant", 32'(last_rdy), 32'h1);
        check("post_rst_id", 32'(resp_id), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom),
                  2'($urandom), $urandom, $urandom,
                  2'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
